// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder: FSM states, data/address
// widths and the request address classifier.
package mem_pkg;

   localparam int ADDR_WIDTH = 16;
   localparam int DATA_WIDTH = 16;
   localparam int WORD_BYTES = 2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS,
      RESP
   } state_e;

   typedef enum logic [1:0] {
      ADDR_OK,
      ADDR_MISALIGNED,
      ADDR_OUT_OF_RANGE
   } addr_class_e;

   // Misalignment wins over range; both end up as an error response anyway.
   function automatic addr_class_e classify_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                 input int unsigned         depth_log2);
      addr_class_e cls;
      cls = ADDR_OK;
      if (addr[$clog2(WORD_BYTES)-1:0] != '0)
         cls = ADDR_MISALIGNED;
      else if ((addr >> (depth_log2 + 1)) != '0)
         cls = ADDR_OUT_OF_RANGE;
      return cls;
   endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: synchronous write, synchronous (registered) read.
module mem_array
   import mem_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clock,
   input  logic                  we,
   input  logic                  re,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [0:(1 << DEPTH_LOG2)-1];

   // Write on we; on re register the addressed word, otherwise hold it.
   // NOTE: the array and its read register have no reset; a reset port would
   // force the storage into flops instead of a RAM macro.
   always_ff @(posedge clock) begin
      if (we)
         mem[addr] <= wdata;
      if (re)
         rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, WAIT_CYCLES wait states, then
// a single access cycle and a held response.
// Optional build macro MEM_PERF_COUNT_EN adds rd_count/wr_count outputs.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err
`ifdef MEM_PERF_COUNT_EN
   ,
   output logic [31:0]           rd_count,
   output logic [31:0]           wr_count
`endif
);

   // Last counter value seen in WAIT before moving on (counter runs 0..W-1,
   // landing on W at the transition edge).
   localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_e                state, state_nxt;
   logic [3:0]            wait_cnt;
   logic                  write_q;
   logic                  err_q;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  ram_we;
   logic                  ram_re;

   // Reset gates the write so an access cycle that coincides with reset is dropped.
   assign ram_we = (state == ACCESS) && write_q && !err_q && !reset;
   assign ram_re = (state == ACCESS) && !write_q && !err_q;

   mem_array #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clock (clock),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (idx_q),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   // State register.
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state and handshake/response outputs.
   // NOTE: every output gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid)
               state_nxt = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
         end
         WAIT: begin
            if (wait_cnt == WAIT_LAST)
               state_nxt = ACCESS;
         end
         ACCESS: begin
            state_nxt = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            // Read register only loads on good reads, so it is stable here.
            resp_rdata = (write_q || err_q) ? '0 : ram_rdata;
            if (resp_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch and wait-state counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt <= '0;
         write_q  <= 1'b0;
         err_q    <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= '0;
      end else if (state == IDLE && req_valid) begin
         wait_cnt <= '0;
         write_q  <= req_write;
         err_q    <= (classify_addr(req_addr, DEPTH_LOG2) != ADDR_OK);
         idx_q    <= req_addr[DEPTH_LOG2:1];
         wdata_q  <= req_wdata;
      end else if (state == WAIT) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

`ifdef MEM_PERF_COUNT_EN
   // Successful access counters, bumped in the access cycle; wrap at 2^32.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         if (ram_re)
            rd_count <= rd_count + 32'd1;
         if (ram_we)
            wr_count <= wr_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: requests push expected responses into a
// queue, an independent monitor compares every cycle a response is presented.
module tb_mem_responder;

   localparam int DEPTH_LOG2  = 10;
   localparam int WAIT_CYCLES = 2;
   localparam int WORDS       = 1 << DEPTH_LOG2;
   localparam int ARRAY_BYTES = 2 * WORDS;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_rdata;
   logic        resp_err;
`ifdef MEM_PERF_COUNT_EN
   logic [31:0] rd_count;
   logic [31:0] wr_count;
`endif

   mem_responder #(
      .DEPTH_LOG2  (DEPTH_LOG2),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
`ifdef MEM_PERF_COUNT_EN
      ,
      .rd_count   (rd_count),
      .wr_count   (wr_count)
`endif
   );

   typedef struct {
      logic        err;
      logic [15:0] rdata;
      bit          chk_data;
      int          acc_cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] mem_m [0:WORDS-1];
   bit          known [0:WORDS-1];
   int          rd_ok_m;
   int          wr_ok_m;
   int          cyc;
   int          errors;
   int          checks;
   bit          hold;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Issue one request, hold it until accepted; optionally record the expectation.
   task automatic send(input logic wr, input logic [15:0] addr, input logic [15:0] wd, input bit push);
      int   n;
      int   idx;
      bit   bad;
      exp_t e;
      @(posedge clock);
      #1;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      n = 0;
      forever begin
         @(negedge clock);
         if (req_ready)
            break;
         n++;
         if (n > 200) begin
            fail("req_ready_timeout");
            break;
         end
      end
      if (push) begin
         bad        = (addr[0] == 1'b1) || (int'(addr) >= ARRAY_BYTES);
         e.err      = bad;
         e.rdata    = 16'h0000;
         e.chk_data = 1'b1;
         e.acc_cyc  = cyc;
         if (!bad) begin
            idx = int'(addr) / 2;
            if (wr) begin
               mem_m[idx] = wd;
               known[idx] = 1'b1;
               wr_ok_m++;
            end else begin
               e.rdata    = mem_m[idx];
               e.chk_data = known[idx];
               rd_ok_m++;
            end
         end
         exp_q.push_back(e);
      end
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = 16'($urandom);
      req_wdata = 16'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clock);
         n++;
      end
      if (exp_q.size() != 0)
         fail("drain_timeout");
      @(posedge clock);
      #1;
   endtask

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clock);
         cyc++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   // Response consumer: random back-pressure unless a hold is requested.
   initial begin
      resp_ready = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         resp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: compare each presented response with the queue head.
   initial begin
      exp_t e;
      bit   in_resp;
      bit   after_hs;
      in_resp  = 1'b0;
      after_hs = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            in_resp  = 1'b0;
            after_hs = 1'b0;
         end else begin
            if (after_hs) begin
               check("req_ready_after_handshake", 32'(req_ready), 32'd1);
               after_hs = 1'b0;
            end
            if (resp_valid) begin
               if (exp_q.size() == 0) begin
                  fail("unexpected_response");
               end else begin
                  e = exp_q[0];
                  if (!in_resp) begin
                     check("latency", 32'(cyc - e.acc_cyc), 32'(WAIT_CYCLES + 2));
                     in_resp = 1'b1;
                  end
                  check("resp_err", 32'(resp_err), 32'(e.err));
                  if (e.chk_data)
                     check("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
                  check("req_ready_during_resp", 32'(req_ready), 32'd0);
                  if (resp_ready) begin
                     void'(exp_q.pop_front());
                     in_resp  = 1'b0;
                     after_hs = 1'b1;
                  end
               end
            end
         end
      end
   end

   initial begin
      int          kind;
      logic [15:0] a;
      errors    = 0;
      checks    = 0;
      rd_ok_m   = 0;
      wr_ok_m   = 0;
      hold      = 1'b0;
      reset     = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 16'h0000;
      req_wdata = 16'h0000;
      for (int i = 0; i < WORDS; i++) begin
         mem_m[i] = 16'h0000;
         known[i] = 1'b0;
      end

      // Reset state.
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_resp_valid", 32'(resp_valid), 32'd0);
      check("reset_resp_rdata", 32'(resp_rdata), 32'd0);
      check("reset_resp_err", 32'(resp_err), 32'd0);

      // Write then read back; misaligned write dropped; range boundary.
      send(1'b1, 16'h0010, 16'h1234, 1'b1);
      send(1'b0, 16'h0010, 16'h0000, 1'b1);
      send(1'b1, 16'h0011, 16'hDEAD, 1'b1);
      send(1'b0, 16'h0010, 16'h0000, 1'b1);
      send(1'b0, 16'h0800, 16'h0000, 1'b1);
      send(1'b1, 16'h07FE, 16'h5A5A, 1'b1);
      send(1'b0, 16'h07FE, 16'h0000, 1'b1);
      send(1'b1, 16'h0020, 16'h1111, 1'b1);
      drain();

      // Back-pressure: response must hold for several cycles.
      hold = 1'b1;
      send(1'b0, 16'h0010, 16'h0000, 1'b1);
      repeat (WAIT_CYCLES + 7) @(posedge clock);
      hold = 1'b0;
      drain();

      // Reset during the access cycle of a write aborts it.
      send(1'b1, 16'h0020, 16'hBEEF, 1'b0);
      repeat (WAIT_CYCLES) @(posedge clock);
      #1;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset   = 1'b0;
      rd_ok_m = 0;
      wr_ok_m = 0;
      repeat (4) begin
         @(negedge clock);
         check("abort_resp_valid", 32'(resp_valid), 32'd0);
      end
      check("abort_req_ready", 32'(req_ready), 32'd1);
      send(1'b0, 16'h0020, 16'h0000, 1'b1);
      drain();

      // Randomised mix of good, misaligned and out-of-range accesses.
      for (int i = 0; i < 150; i++) begin
         kind = int'($urandom_range(0, 9));
         if (kind == 0)
            a = 16'h0101 + 16'(2 * $urandom_range(0, 15));
         else if (kind == 1)
            a = 16'(2 * $urandom_range(WORDS, 32767));
         else
            a = 16'h0100 + 16'(2 * $urandom_range(0, 15));
         send(1'($urandom_range(0, 1)), a, 16'($urandom), 1'b1);
      end
      drain();

`ifdef MEM_PERF_COUNT_EN
      check("rd_count", rd_count, 32'(rd_ok_m));
      check("wr_count", wr_count, 32'(wr_ok_m));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
